datapath_controller: RTL and testbench
======================================

# datapath_controller

Microcoded sequencer for the scheduled four-unit datapath (one add/sub ALU, one mul/div unit, two logic units, seven intermediate registers, result register). It holds a small writable control store with one control word per control step. After a start pulse it plays the words out one per cycle as mux selects, unit opcodes and register enables, then pulses `result_en`/`done_next` so the datapath latches `result` and raises `done`. It sits between the top-level host interface and the datapath and is the datapath's only source of control.

## Interface
- `DEPTH`, 16, number of control words (2..16).
- `ADDR_W`, 4, control-store address width; `2**ADDR_W >= DEPTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run the stored program.
- `cfg_we`  in  1  control-store write strobe.
- `cfg_addr`  in  ADDR_W  control-store write address.
- `cfg_wdata`  in  46  control word.
- `alu1_sel1`, `alu1_sel2`, `mul1_sel1`, `mul1_sel2`, `log1_sel1`, `log1_sel2`, `log2_sel1`, `log2_sel2`  out  4 each  operand selects (0–7 = i1–i8, 8–14 = intermediate regs, 15 = zero).
- `alu1_op`, `mul1_op`  out  1 each  0 = add/mul, 1 = sub/div.
- `log1_op`, `log2_op`  out  2 each  00 = AND, 01 = OR, 10 = XOR.
- `reg_log2_en`, `reg_log5_en`, `reg_alu6_en`, `reg_log9_en`, `reg_log12_en`, `reg_alu13_en`, `reg_mul14_en`  out  1 each  intermediate register write enables.
- `result_en`  out  1  result register load (1-cycle pulse).
- `done_next`  out  1  fed to the datapath's done flop (1-cycle pulse).
- `busy`  out  1  high in RUN and FIN.
- `steps`  out  ADDR_W+1  number of words executed by the last completed run.
- `cfg_err`  out  1  sticky flag: a write was dropped.

## Operation
- Control word bit fields: [6:0] enables (bit0 `reg_log2_en` … bit6 `reg_mul14_en`, in port order); [10:7] `alu1_sel1`; [14:11] `alu1_sel2`; [15] `alu1_op`; [19:16] `mul1_sel1`; [23:20] `mul1_sel2`; [24] `mul1_op`; [28:25] `log1_sel1`; [32:29] `log1_sel2`; [34:33] `log1_op`; [38:35] `log2_sel1`; [42:39] `log2_sel2`; [44:43] `log2_op`; [45] `last`.
- FSM states:
  - **IDLE.** If `start` is high, go to RUN with pc=0 and load the registered control outputs with word 0.
  - **RUN.** Outputs reflect word pc.
    - If word pc has `last`=1, or pc=DEPTH-1, go to FIN and set `steps` = pc+1.
    - Otherwise pc++ and load word pc+1.
  - **FIN.** All enables, selects and ops are 0. `result_en`=1, `done_next`=1. Go to IDLE.
- All datapath control outputs are registered. In IDLE and FIN every select, op and register enable is 0.
- `start` is ignored in RUN and FIN. There is no queueing.
- `cfg_we` in IDLE writes `cfg_wdata` into `mem[cfg_addr]`.
- `cfg_we` in RUN/FIN, or with `cfg_addr` >= DEPTH, is dropped and sets `cfg_err`. An accepted `start` clears `cfg_err`.
- Control-store writes in the same cycle as an accepted `start` take effect before word 0 is read. Word 0 then reflects the new data.
- A stored `log*_op`=11 is passed through unchanged; the datapath produces 0 for that code.
- Reset clears state to IDLE, pc, `steps`, `cfg_err` and all outputs to 0. The control-store contents are not reset and survive `rst`.
- Reset mid-run aborts immediately: outputs go to 0 with no `result_en` or `done_next` pulse.

## Timing
- Start accepted at edge E0. Word k drives the datapath during cycle E0+k and is committed at edge E0+k+1.
- N-word program: FIN occupies cycle E0+N. `result` loads at edge E0+N+1, and the datapath `done` is high from edge E0+N+1 for one cycle.
- `busy` rises at E0 and falls at E0+N+1. A new `start` can be accepted in the cycle `busy` is low, i.e. back-to-back runs with one IDLE cycle.
- Maximum latency is DEPTH+1 cycles from start to `done_next`.

## Test plan
- Write 3 words: w0 = log1 AND i1,i2 → en bit0; w1 = mul i2×i3 → bit6; w2 = last, no enables. `start` → `busy` is high for 4 cycles, `result_en` pulses exactly at cycle E0+3, `steps`=3. With i1=0xF0, i2=0x3C, i3=2, `reg_mul14`=0x78.
- No `last` bit anywhere with DEPTH=16 → 16 RUN cycles then FIN, `steps`=16.
- `cfg_we` during RUN at addr 2 → `mem[2]` is unchanged (rerun gives the same result) and `cfg_err`=1. The next `start` clears it.
- `start` pulsed again at E0+1 → ignored, and only one `done_next` pulse occurs.
- `rst` asserted at E0+1 of a 3-word run → all outputs are 0 asynchronously and no `result_en` occurs. A following `start` reruns correctly without rewriting the control store.
- Write to addr 0 and `start` in the same cycle → cycle E0 outputs match the new word.

Source files
------------

// File: rtl/datapath_controller_if.sv
// Host/datapath bundle for the microcoded datapath sequencer.
// The controller sits on the slave modport; the host side (and the bench) uses master.
interface datapath_controller_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [45:0]       cfg_wdata;

    logic [3:0]        alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2;
    logic [3:0]        log1_sel1, log1_sel2, log2_sel1, log2_sel2;
    logic              alu1_op, mul1_op;
    logic [1:0]        log1_op, log2_op;
    logic              reg_log2_en, reg_log5_en, reg_alu6_en, reg_log9_en;
    logic              reg_log12_en, reg_alu13_en, reg_mul14_en;
    logic              result_en;
    logic              done_next;
    logic              busy;
    logic [ADDR_W:0]   steps;
    logic              cfg_err;

    modport master (
        output start, cfg_we, cfg_addr, cfg_wdata,
        input  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2,
               log1_sel1, log1_sel2, log2_sel1, log2_sel2,
               alu1_op, mul1_op, log1_op, log2_op,
               reg_log2_en, reg_log5_en, reg_alu6_en, reg_log9_en,
               reg_log12_en, reg_alu13_en, reg_mul14_en,
               result_en, done_next, busy, steps, cfg_err
    );

    modport slave (
        input  start, cfg_we, cfg_addr, cfg_wdata,
        output alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2,
               log1_sel1, log1_sel2, log2_sel1, log2_sel2,
               alu1_op, mul1_op, log1_op, log2_op,
               reg_log2_en, reg_log5_en, reg_alu6_en, reg_log9_en,
               reg_log12_en, reg_alu13_en, reg_mul14_en,
               result_en, done_next, busy, steps, cfg_err
    );
endinterface

// File: rtl/datapath_controller.sv
// Microcoded sequencer: a writable control store played out one word per cycle
// after a start pulse, followed by a single FIN cycle that loads the result.
// The current control word is held in one register and all datapath controls
// are slices of it, so every output is registered and zero outside RUN.
module datapath_controller #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    datapath_controller_if.slave   dp
);

    localparam int              LAST_BIT = 45;
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [45:0]       mem_r [0:(2**ADDR_W)-1];
    logic [45:0]       ctl_r, ctl_s;
    logic [ADDR_W-1:0] pc_r, pc_s, pc_inc_s;
    logic [ADDR_W:0]   steps_r, steps_s;
    logic              cfg_err_r, cfg_err_s;
    logic              result_en_r, result_en_s;
    logic              done_next_r, done_next_s;
    logic              busy_r, busy_s;
    logic              addr_ok_s, wr_accept_s, wr_drop_s, start_acc_s;
    logic [45:0]       word0_s;

    // Write acceptance and the word-0 bypass for a write landing with start
    always_comb begin
        addr_ok_s   = ({1'b0, dp.cfg_addr} < DEPTH_W);
        wr_accept_s = dp.cfg_we && addr_ok_s && (state_r == ST_IDLE);
        wr_drop_s   = dp.cfg_we && !wr_accept_s;
        pc_inc_s    = pc_r + PC_ONE;
        if (wr_accept_s && (dp.cfg_addr == {ADDR_W{1'b0}})) begin
            word0_s = dp.cfg_wdata;
        end else begin
            word0_s = mem_r[0];
        end
    end

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_s     = state_r;
        ctl_s       = {46{1'b0}};
        pc_s        = pc_r;
        steps_s     = steps_r;
        result_en_s = 1'b0;
        done_next_s = 1'b0;
        busy_s      = 1'b0;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dp.start) begin
                    state_s     = ST_RUN;
                    pc_s        = {ADDR_W{1'b0}};
                    ctl_s       = word0_s;
                    busy_s      = 1'b1;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (ctl_r[LAST_BIT] || (pc_r == LAST_PC)) begin
                    state_s     = ST_FIN;
                    steps_s     = {1'b0, pc_r} + (ADDR_W+1)'(1'b1);
                    result_en_s = 1'b1;
                    done_next_s = 1'b1;
                end else begin
                    pc_s  = pc_inc_s;
                    ctl_s = mem_r[pc_inc_s];
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A dropped write in the start cycle stays flagged rather than lost
        cfg_err_s = wr_drop_s | (cfg_err_r & ~start_acc_s);
    end

    // Control store: not reset, so programs survive rst
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[dp.cfg_addr] <= dp.cfg_wdata;
        end
    end

    // Sequencer state and registered outputs; reset aborts a run silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ctl_r       <= {46{1'b0}};
            pc_r        <= {ADDR_W{1'b0}};
            steps_r     <= {(ADDR_W+1){1'b0}};
            cfg_err_r   <= 1'b0;
            result_en_r <= 1'b0;
            done_next_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ctl_r       <= ctl_s;
            pc_r        <= pc_s;
            steps_r     <= steps_s;
            cfg_err_r   <= cfg_err_s;
            result_en_r <= result_en_s;
            done_next_r <= done_next_s;
            busy_r      <= busy_s;
        end
    end

    assign dp.reg_log2_en  = ctl_r[0];
    assign dp.reg_log5_en  = ctl_r[1];
    assign dp.reg_alu6_en  = ctl_r[2];
    assign dp.reg_log9_en  = ctl_r[3];
    assign dp.reg_log12_en = ctl_r[4];
    assign dp.reg_alu13_en = ctl_r[5];
    assign dp.reg_mul14_en = ctl_r[6];
    assign dp.alu1_sel1    = ctl_r[10:7];
    assign dp.alu1_sel2    = ctl_r[14:11];
    assign dp.alu1_op      = ctl_r[15];
    assign dp.mul1_sel1    = ctl_r[19:16];
    assign dp.mul1_sel2    = ctl_r[23:20];
    assign dp.mul1_op      = ctl_r[24];
    assign dp.log1_sel1    = ctl_r[28:25];
    assign dp.log1_sel2    = ctl_r[32:29];
    assign dp.log1_op      = ctl_r[34:33];
    assign dp.log2_sel1    = ctl_r[38:35];
    assign dp.log2_sel2    = ctl_r[42:39];
    assign dp.log2_op      = ctl_r[44:43];
    assign dp.result_en    = result_en_r;
    assign dp.done_next    = done_next_r;
    assign dp.busy         = busy_r;
    assign dp.steps        = steps_r;
    assign dp.cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: directed test-plan sequences,
// a table of program lengths and randomized programs against a run-level model.
module tb_datapath_controller;

    localparam int DEPTH = 16;
    localparam logic [45:0] OUT_MASK = {1'b0, {45{1'b1}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [45:0] mem_m [0:DEPTH-1];
    logic        err_m = 1'b0;

    datapath_controller_if #(.ADDR_W(4)) dif();

    datapath_controller #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int last_pos;
        int exp_steps;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reassemble the datapath-control ports into the control-word layout
    function automatic logic [45:0] obs();
        return {1'b0, dif.log2_op, dif.log2_sel2, dif.log2_sel1,
                dif.log1_op, dif.log1_sel2, dif.log1_sel1,
                dif.mul1_op, dif.mul1_sel2, dif.mul1_sel1,
                dif.alu1_op, dif.alu1_sel2, dif.alu1_sel1,
                dif.reg_mul14_en, dif.reg_alu13_en, dif.reg_log12_en,
                dif.reg_log9_en, dif.reg_alu6_en, dif.reg_log5_en, dif.reg_log2_en};
    endfunction

    // Program length: up to and including the first word marked last
    function automatic int prog_len();
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_m[i][45]) return i + 1;
        end
        return DEPTH;
    endfunction

    task automatic write_word(input logic [3:0] addr, input logic [45:0] data);
        dif.cfg_we    = 1'b1;
        dif.cfg_addr  = addr;
        dif.cfg_wdata = data;
        mem_m[addr]   = data;
        tick();
        dif.cfg_we = 1'b0;
    endtask

    function automatic logic [45:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[45] = 1'b0;
        return r[45:0];
    endfunction

    // Start a run and compare every cycle against the model up to the IDLE cycle after FIN
    task automatic run_check(input string nm,
                             input bit pre_wr, input logic [3:0] pre_addr, input logic [45:0] pre_data,
                             input int inj_cyc, input logic [3:0] inj_addr, input logic [45:0] inj_data,
                             input int st2_cyc);
        int n;
        int pulses;
        logic [45:0] exp;
        dif.start = 1'b1;
        if (pre_wr) begin
            dif.cfg_we    = 1'b1;
            dif.cfg_addr  = pre_addr;
            dif.cfg_wdata = pre_data;
            mem_m[pre_addr] = pre_data;
        end
        n = prog_len();
        tick();
        dif.start  = 1'b0;
        dif.cfg_we = 1'b0;
        err_m  = 1'b0;
        pulses = 0;
        for (int c = 0; c <= n + 1; c++) begin
            exp = (c < n) ? (mem_m[c] & OUT_MASK) : 46'd0;
            chk($sformatf("%s.c%0d.word", nm, c), 64'(obs()), 64'(exp));
            chk($sformatf("%s.c%0d.busy", nm, c), 64'(dif.busy), 64'(c <= n));
            chk($sformatf("%s.c%0d.result_en", nm, c), 64'(dif.result_en), 64'(c == n));
            chk($sformatf("%s.c%0d.done_next", nm, c), 64'(dif.done_next), 64'(c == n));
            chk($sformatf("%s.c%0d.cfg_err", nm, c), 64'(dif.cfg_err), 64'(err_m));
            if (c == n + 1) chk($sformatf("%s.steps", nm), 64'(dif.steps), 64'(n));
            pulses += int'(dif.done_next);
            if (c <= n) begin
                if (c == inj_cyc) begin
                    dif.cfg_we    = 1'b1;
                    dif.cfg_addr  = inj_addr;
                    dif.cfg_wdata = inj_data;
                end
                if (c == st2_cyc) dif.start = 1'b1;
                tick();
                dif.cfg_we = 1'b0;
                dif.start  = 1'b0;
                if (c == inj_cyc) err_m = 1'b1;
            end
        end
        chk($sformatf("%s.done_pulses", nm), 64'(pulses), 64'd1);
    endtask

    task automatic load_prog(input int last_pos);
        logic [45:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = rand_word();
            w[45] = (i == last_pos);
            write_word(4'(i), w);
        end
    endtask

    initial begin
        vec_t tbl[5];
        int   cnt;
        logic [45:0] w;

        tbl[0] = '{last_pos: 0,  exp_steps: 1};
        tbl[1] = '{last_pos: 2,  exp_steps: 3};
        tbl[2] = '{last_pos: 9,  exp_steps: 10};
        tbl[3] = '{last_pos: 15, exp_steps: 16};
        tbl[4] = '{last_pos: -1, exp_steps: 16};

        dif.start = 1'b0; dif.cfg_we = 1'b0; dif.cfg_addr = 4'd0; dif.cfg_wdata = 46'd0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 46'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst.word", 64'(obs()), 64'd0);
        chk("rst.busy", 64'(dif.busy), 64'd0);
        chk("rst.steps", 64'(dif.steps), 64'd0);
        chk("rst.cfg_err", 64'(dif.cfg_err), 64'd0);
        chk("rst.result_en", 64'(dif.result_en), 64'd0);
        chk("rst.done_next", 64'(dif.done_next), 64'd0);

        // Three-word program: log1 AND i1,i2 -> en0; mul i2*i3 -> en6; last
        write_word(4'd0, (46'd1 << 29) | 46'd1);
        write_word(4'd1, (46'd1 << 16) | (46'd2 << 20) | (46'd1 << 6));
        write_word(4'd2, 46'd1 << 45);
        run_check("tp3", 1'b0, 4'd0, 46'd0, -1, 4'd0, 46'd0, -1);

        // Write during RUN is dropped and flagged; rerun must see the old word and clear the flag
        run_check("wr_in_run", 1'b0, 4'd0, 46'd0, 1, 4'd2, 46'h3FFF_FFFF_FFFF, -1);
        run_check("rerun", 1'b0, 4'd0, 46'd0, -1, 4'd0, 46'd0, -1);

        // Second start during RUN is ignored
        run_check("restart", 1'b0, 4'd0, 46'd0, -1, 4'd0, 46'd0, 1);

        // Reset at E0+1 aborts asynchronously with no result pulse
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort.word", 64'(obs()), 64'd0);
        chk("abort.busy", 64'(dif.busy), 64'd0);
        chk("abort.steps", 64'(dif.steps), 64'd0);
        chk("abort.result_en", 64'(dif.result_en), 64'd0);
        chk("abort.done_next", 64'(dif.done_next), 64'd0);
        cnt = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cnt += int'(dif.result_en) + int'(dif.done_next) + int'(dif.busy);
            tick();
        end
        chk("abort.no_pulse", 64'(cnt), 64'd0);
        run_check("after_rst", 1'b0, 4'd0, 46'd0, -1, 4'd0, 46'd0, -1);

        // Write to word 0 in the start cycle takes effect immediately
        w = rand_word();
        run_check("wr_with_start", 1'b1, 4'd0, w, -1, 4'd0, 46'd0, -1);

        // Table of program lengths
        foreach (tbl[i]) begin
            load_prog(tbl[i].last_pos);
            run_check($sformatf("tbl%0d", i), 1'b0, 4'd0, 46'd0, -1, 4'd0, 46'd0, -1);
            chk($sformatf("tbl%0d.steps_exp", i), 64'(dif.steps), 64'(tbl[i].exp_steps));
        end

        // Randomized programs with random late writes and stray starts
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = rand_word();
                w[45] = ($urandom_range(0, 5) == 0);
                write_word(4'(i), w);
            end
            w = rand_word();
            w[45] = ($urandom_range(0, 3) == 0);
            run_check($sformatf("rnd%0d", it),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), w,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1,
                      4'($urandom_range(0, 15)), rand_word(),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
